// File: rtl/fifo_ctrl_16x8_pkg.sv
// Shared sizing constants and pointer type for the 16x8 FIFO controller.
package fifo_ctrl_16x8_pkg;
  localparam int unsigned DEF_ADDR_BUS = 4;
  localparam int unsigned DEF_DEPTH    = 1 << DEF_ADDR_BUS;
  localparam int unsigned PTR_W        = DEF_ADDR_BUS + 1;

  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_ctrl_16x8_ptr.sv
// Pointer register with wrap bit: async reset, synchronous flush, modulo increment.
module fifo_ptr
  import fifo_ctrl_16x8_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl_16x8.sv
// Pointer/flag controller turning a 16x8 dual-port synchronous RAM into a FIFO.
module fifo_ctrl_16x8
  import fifo_ctrl_16x8_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ADDR_BUS  = DEF_ADDR_BUS,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic                err_clr,
  output logic                we,
  output logic                re,
  output logic [ADDR_BUS-1:0] wr_addr,
  output logic [ADDR_BUS-1:0] rd_addr,
  output logic                rd_valid,
  output logic [ADDR_BUS:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  if (DEPTH != (1 << ADDR_BUS)) begin : g_bad_depth
    $error("fifo_ctrl_16x8: DEPTH must equal 2**ADDR_BUS");
  end
  if (AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_ctrl_16x8: AFULL_TH must not exceed DEPTH");
  end

  localparam logic [ADDR_BUS:0] AFULL_C  = AFULL_TH[ADDR_BUS:0];
  localparam logic [ADDR_BUS:0] AEMPTY_C = AEMPTY_TH[ADDR_BUS:0];

  logic [ADDR_BUS:0] wr_ptr;
  logic [ADDR_BUS:0] rd_ptr;

  fifo_ptr #(.W(ADDR_BUS + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (we),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(ADDR_BUS + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (re),
    .ptr   (rd_ptr)
  );

  always_comb begin
    wr_addr      = wr_ptr[ADDR_BUS-1:0];
    rd_addr      = rd_ptr[ADDR_BUS-1:0];
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDR_BUS] != rd_ptr[ADDR_BUS]) &&
                   (wr_ptr[ADDR_BUS-1:0] == rd_ptr[ADDR_BUS-1:0]);
    almost_full  = (count >= AFULL_C);
    almost_empty = (count <= AEMPTY_C);
    // Strobes are qualified by rst_n so the RAM sees no access while reset is held.
    we           = push & ~full & ~flush & rst_n;
    re           = pop & ~empty & ~flush & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= re;
      if (push & full & ~flush) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (pop & empty & ~flush) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Scoreboard bench for fifo_ctrl_16x8 with a behavioural RAM and queue-based FIFO model.
module tb_fifo_ctrl_16x8;
  logic       clk = 1'b0;
  logic       rst_n, flush, push, pop, err_clr;
  logic       we, re, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] wr_addr, rd_addr;
  logic [4:0] count;
  logic [7:0] din, dout;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         wr_tot, rd_tot;
  bit         ovf_m, udf_m, rv_m;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];

  fifo_ctrl_16x8 #(.DEPTH(16), .ADDR_BUS(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop), .err_clr(err_clr),
    .we(we), .re(re), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wr_addr] <= din;
    if (re) dout <= mem[rd_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_tot = 0; rd_tot = 0;
    ovf_m = 0; udf_m = 0; rv_m = 0;
    mq.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_we", we, 0);
    chk("rst_re", re, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
  endtask

  task automatic check_state();
    int c;
    c = wr_tot - rd_tot;
    chk("count", count, c);
    chk("full", full, int'(c == 16));
    chk("empty", empty, int'(c == 0));
    chk("almost_full", almost_full, int'(c >= 14));
    chk("almost_empty", almost_empty, int'(c <= 2));
    chk("wr_addr", wr_addr, wr_tot % 16);
    chk("rd_addr", rd_addr, rd_tot % 16);
    chk("overflow", overflow, ovf_m);
    chk("underflow", underflow, udf_m);
    chk("rd_valid", rd_valid, rv_m);
  endtask

  task automatic step(input bit p, input bit q, input bit f, input bit ec, input logic [7:0] d);
    int  c;
    bit  acc_w, acc_r;
    @(negedge clk);
    check_state();
    push = p; pop = q; flush = f; err_clr = ec; din = d;
    c = wr_tot - rd_tot;
    acc_w = p && (c < 16) && !f;
    acc_r = q && (c > 0) && !f;
    #1;
    chk("we", we, acc_w);
    chk("re", re, acc_r);
    @(posedge clk);
    if (p && c == 16 && !f) ovf_m = 1; else if (ec) ovf_m = 0;
    if (q && c == 0 && !f)  udf_m = 1; else if (ec) udf_m = 0;
    rv_m = acc_r;
    if (f) begin
      wr_tot = 0; rd_tot = 0;
      mq.delete();
    end else begin
      if (acc_w) begin mq.push_back(d); wr_tot++; end
      if (acc_r) begin exp_q.push_back(mq.pop_front()); rd_tot++; end
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    push = 1; pop = 1;
    #2 rst_n = 0;
    #1 check_reset_vals();
    model_reset();
    @(negedge clk);
    push = 0; pop = 0;
    rst_n = 1;
  endtask

  // Monitor: every presented read is matched against the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 1, 0);
        end else begin
          chk("dout", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 0; flush = 0; push = 0; pop = 0; err_clr = 0; din = '0;
    model_reset();
    #3 check_reset_vals();
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 8'hA0 + 8'(i % 16));
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'($urandom));

    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h5A);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 8'($urandom));
    step(1, 1, 0, 0, 8'hEE);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h3C);
    step(0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 8'($urandom));
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h77);
    step(1, 1, 1, 0, 8'h99);
    step(0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++)
      step(($urandom % 10) < 6, ($urandom % 10) < 5, ($urandom % 40) == 0,
           ($urandom % 20) == 0, 8'($urandom));

    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'($urandom));
    step(0, 1, 0, 0, 8'h00);
    mid_reset();
    for (int i = 0; i < 20; i++) step(1, ($urandom % 2) == 0, 0, 0, 8'($urandom));

    for (int i = 0; i < 40 && (wr_tot - rd_tot) > 0; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    chk("drained_count", wr_tot - rd_tot, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
